// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch-stage constants and state encoding
package fetch_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_2000;
  typedef enum logic {REQ = 1'b0, WAIT = 1'b1} fetch_state_e;
endpackage

// File: rtl/fetch_out_reg.sv
// fetch_out_reg: single-entry valid/ready register with load, flush and reset values
module fetch_out_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic        ready,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  input  logic [31:0] reset_instr,
  input  logic [31:0] reset_pc,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc
);
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= reset_instr;
      pc <= reset_pc;
    end else begin
      valid <= !flush && (load || (valid && !ready));
      if (load && !flush) begin
        instr <= load_instr;
        pc <= load_pc;
      end
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: pc, single-outstanding imem request handshake and redirect handling
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);
  fetch_state_e state, state_d;
  logic [31:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic drop_q, drop_d, req_fire, load;
  assign imem_req_valid = state == REQ && !redirect_valid && (!out_valid || out_ready);
  assign imem_req_addr = pc_q;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign load = state == WAIT && imem_resp_valid && !drop_q && !redirect_valid;
  always_comb begin
    state_d = state == REQ ? (req_fire ? WAIT : REQ) : (imem_resp_valid ? REQ : WAIT);
    pc_d = redirect_valid ? redirect_pc & ~32'd3 : req_fire ? pc_q + 32'd4 : pc_q;
    req_pc_d = req_fire ? pc_q : req_pc_q;
    drop_d = state == WAIT && !imem_resp_valid && (drop_q || redirect_valid);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= REQ;
      pc_q <= RESET_PC & ~32'd3;
      req_pc_q <= 32'd0;
      drop_q <= 1'b0;
    end else begin
      state <= state_d;
      pc_q <= pc_d;
      req_pc_q <= req_pc_d;
      drop_q <= drop_d;
    end
  end
  fetch_out_reg u_out (
    .clk(clk),
    .rst(rst),
    .load(load),
    .flush(redirect_valid),
    .ready(out_ready),
    .load_instr(imem_resp_data),
    .load_pc(req_pc_q),
    .reset_instr(NOP_INSTR),
    .reset_pc(32'd0),
    .valid(out_valid),
    .instr(out_instr),
    .pc(out_pc)
  );
  a_no_load_on_transfer: assert property (@(posedge clk) disable iff (rst) !(load && out_valid && out_ready));
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random checks of fetch_unit against a stream-level model
module tb_fetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, imem_req_valid, imem_req_ready = 1'b0, imem_resp_valid = 1'b0;
  logic redirect_valid = 1'b0, out_valid, out_ready = 1'b0;
  logic [31:0] imem_req_addr, imem_resp_data = '0, redirect_pc = '0, out_instr, out_pc;
  logic rst2 = 1'b1, req_valid2, req_ready2 = 1'b0, resp_valid2 = 1'b0, out_valid2;
  logic [31:0] req_addr2, resp_data2 = '0, out_instr2, out_pc2;
  fetch_unit u_dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
  );
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst2),
    .imem_req_valid(req_valid2), .imem_req_ready(req_ready2), .imem_req_addr(req_addr2),
    .imem_resp_valid(resp_valid2), .imem_resp_data(resp_data2),
    .redirect_valid(1'b0), .redirect_pc(32'd0),
    .out_valid(out_valid2), .out_ready(1'b1), .out_instr(out_instr2), .out_pc(out_pc2)
  );
  int n_vec = 0, n_err = 0, n_deliv = 0;
  logic d_rst = 1'b1, d_ordy = 1'b1, d_rrdy = 1'b1, d_redir = 1'b0;
  logic [31:0] d_rpc = '0;
  logic d_rst2 = 1'b1, d_rdy2 = 1'b0, d_rv2 = 1'b0;
  logic [31:0] d_rd2 = '0;
  int lat = 0, cnt = 0;
  logic outst = 1'b0;
  logic [31:0] maddr = '0, exp_fetch, exp_deliv, p_addr = '0, p_pc = '0, p_instr = '0;
  logic p_rst = 1'b1, p_redir = 1'b0, p_req = 1'b0, p_hold = 1'b0;
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a == 32'h2000 ? 32'h0050_0093 : {a[29:0], 2'b11} ^ 32'hA5A5_0000;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    logic fire, deliv;
    @(negedge clk);
    rst = d_rst;
    out_ready = d_ordy;
    redirect_valid = d_redir;
    redirect_pc = d_rpc;
    imem_req_ready = d_rrdy;
    imem_resp_valid = outst && cnt == 0;
    imem_resp_data = memfn(maddr);
    rst2 = d_rst2;
    req_ready2 = d_rdy2;
    resp_valid2 = d_rv2;
    resp_data2 = d_rd2;
    #1;
    if (d_rst) begin
      exp_fetch = 32'h2000;
      exp_deliv = 32'h2000;
      outst = 1'b0;
      p_rst = 1'b1;
      p_redir = 1'b0;
      p_req = 1'b0;
      p_hold = 1'b0;
      return;
    end
    fire = imem_req_valid && d_rrdy;
    deliv = out_valid && d_ordy;
    if (p_rst) begin
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_pc", out_pc, 32'd0);
      check("rst_out_instr", out_instr, 32'h0000_0013);
      check("rst_req_valid", {31'd0, imem_req_valid}, {31'd0, !d_redir});
    end
    if (p_redir) check("flush_after_redirect", {31'd0, out_valid}, 32'd0);
    if (d_redir) check("no_req_on_redirect", {31'd0, imem_req_valid}, 32'd0);
    if (imem_req_valid) check("req_align", {30'd0, imem_req_addr[1:0]}, 32'd0);
    if (p_req && imem_req_valid) check("req_hold", imem_req_addr, p_addr);
    if (p_hold) begin
      check("out_hold_valid", {31'd0, out_valid}, 32'd1);
      check("out_hold_pc", out_pc, p_pc);
      check("out_hold_instr", out_instr, p_instr);
    end
    if (fire) begin
      check("one_outstanding", {31'd0, outst}, 32'd0);
      check("req_addr", imem_req_addr, exp_fetch);
      exp_fetch += 32'd4;
    end
    if (deliv) begin
      check("deliv_pc", out_pc, exp_deliv);
      check("deliv_instr", out_instr, memfn(exp_deliv));
      exp_deliv += 32'd4;
      n_deliv++;
    end
    if (d_redir) begin
      exp_fetch = d_rpc & ~32'd3;
      exp_deliv = d_rpc & ~32'd3;
    end
    p_req = imem_req_valid && !fire && !d_redir;
    p_addr = imem_req_addr;
    p_hold = out_valid && !d_ordy && !d_redir;
    p_pc = out_pc;
    p_instr = out_instr;
    p_redir = d_redir;
    p_rst = 1'b0;
    if (imem_resp_valid) outst = 1'b0;
    else if (outst) cnt--;
    if (fire) begin
      outst = 1'b1;
      maddr = imem_req_addr;
      cnt = lat;
    end
  endtask
  initial begin
    step();
    step();
    d_rst2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("wrap_stall_valid", {31'd0, req_valid2}, 32'd1);
      check("wrap_stall_addr", req_addr2, 32'hFFFF_FFFC);
    end
    d_rdy2 = 1'b1;
    step();
    check("wrap_fire_addr", req_addr2, 32'hFFFF_FFFC);
    d_rdy2 = 1'b0;
    d_rv2 = 1'b1;
    d_rd2 = 32'h1357_9BDF;
    step();
    check("wrap_wait_no_req", {31'd0, req_valid2}, 32'd0);
    d_rv2 = 1'b0;
    d_rdy2 = 1'b1;
    step();
    check("wrap_out_valid", {31'd0, out_valid2}, 32'd1);
    check("wrap_out_pc", out_pc2, 32'hFFFF_FFFC);
    check("wrap_out_instr", out_instr2, 32'h1357_9BDF);
    check("wrap_next_addr", req_addr2, 32'h0000_0000);
    d_rst2 = 1'b1;
    step();
    d_rst = 1'b0;
    step();
    check("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("first_req_addr", imem_req_addr, 32'h2000);
    step();
    check("wait_no_req", {31'd0, imem_req_valid}, 32'd0);
    step();
    check("first_out_valid", {31'd0, out_valid}, 32'd1);
    check("first_out_instr", out_instr, 32'h0050_0093);
    check("first_out_pc", out_pc, 32'h2000);
    check("second_req_addr", imem_req_addr, 32'h2004);
    step();
    d_ordy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_no_req", {31'd0, imem_req_valid}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_pc", out_pc, 32'h2004);
    end
    d_ordy = 1'b1;
    lat = 2;
    step();
    check("bp_release_req", {31'd0, imem_req_valid}, 32'd1);
    check("bp_release_addr", imem_req_addr, 32'h2008);
    d_redir = 1'b1;
    d_rpc = 32'h3001;
    step();
    d_redir = 1'b0;
    lat = 0;
    step();
    step();
    check("drop_no_out", {31'd0, out_valid}, 32'd0);
    step();
    check("drop_no_out2", {31'd0, out_valid}, 32'd0);
    check("redir_req_addr", imem_req_addr, 32'h3000);
    step();
    step();
    check("redir_out_valid", {31'd0, out_valid}, 32'd1);
    check("redir_out_pc", out_pc, 32'h3000);
    d_redir = 1'b1;
    d_rpc = 32'h5000;
    step();
    d_redir = 1'b0;
    step();
    check("coinc_out_valid", {31'd0, out_valid}, 32'd0);
    check("coinc_req_addr", imem_req_addr, 32'h5000);
    step();
    d_ordy = 1'b0;
    step();
    check("coinc_deliv_valid", {31'd0, out_valid}, 32'd1);
    check("coinc_deliv_pc", out_pc, 32'h5000);
    d_redir = 1'b1;
    d_rpc = 32'h4000;
    step();
    d_redir = 1'b0;
    d_ordy = 1'b1;
    step();
    check("buf_flushed", {31'd0, out_valid}, 32'd0);
    check("buf_req_addr", imem_req_addr, 32'h4000);
    step();
    step();
    check("buf_out_valid", {31'd0, out_valid}, 32'd1);
    check("buf_out_pc", out_pc, 32'h4000);
    n_deliv = 0;
    for (int i = 0; i < 4000; i++) begin
      d_rst = $urandom_range(499, 0) == 0;
      d_redir = $urandom_range(11, 0) == 0;
      d_rpc = $urandom;
      d_ordy = $urandom_range(3, 0) != 0;
      d_rrdy = $urandom_range(3, 0) != 0;
      lat = $urandom_range(3, 0);
      step();
    end
    check("random_progress", {31'd0, n_deliv > 200}, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
